// File: rtl/addi_shared_arbiter.sv
// addi_shared_arbiter
//   Shares one pipelined adder among NUM_REQ elastic requesters. Each requester
//   offers an (lhs, rhs) pair; a round-robin arbiter picks one joined pair per
//   cycle, the sum travels down a LATENCY-deep bubble-collapsing pipeline tagged
//   with its requester index, and leaves on that requester's result channel.
//
//   Parameters
//     DATA_TYPE : operand/result width in bits
//     NUM_REQ   : number of requesters (2..8)
//     LATENCY   : adder pipeline depth (1..4)
//
//   Ports
//     clk, rst                  : clock, synchronous active-high reset
//     lhs/rhs                   : packed operands, requester i at [i*DATA_TYPE +: DATA_TYPE]
//     lhs_valid/rhs_valid       : per-requester operand valids
//     lhs_ready/rhs_ready       : per-requester operand readies (only the granted one)
//     result                    : last-stage sum replicated into every slice
//     result_valid/result_ready : per-requester result handshake
//     conflict_count            : saturating count of cycles with >=2 eligible
//                                 requesters; present only when
//                                 ADDI_SHARED_ARBITER_CONFLICT_COUNT_EN is defined
module addi_shared_arbiter #(
  parameter int DATA_TYPE = 32,
  parameter int NUM_REQ   = 2,
  parameter int LATENCY   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   lhs,
  input  logic [NUM_REQ-1:0]             lhs_valid,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   rhs,
  input  logic [NUM_REQ-1:0]             rhs_valid,
  output logic [NUM_REQ-1:0]             lhs_ready,
  output logic [NUM_REQ-1:0]             rhs_ready,
  output logic [NUM_REQ*DATA_TYPE-1:0]   result,
  output logic [NUM_REQ-1:0]             result_valid,
  input  logic [NUM_REQ-1:0]             result_ready
`ifdef ADDI_SHARED_ARBITER_CONFLICT_COUNT_EN
  ,
  output logic [31:0]                    conflict_count
`endif
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                  elig;
  logic [TAG_W-1:0]                    last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]                  grant;
  logic [TAG_W-1:0]                    grant_idx;
  logic [TAG_W-1:0]                    cand;
  logic                                grant_any;
  logic                                accept;
  logic [DATA_TYPE-1:0]                op_sum;

  logic [LATENCY-1:0]                  valid_q, valid_d;
  logic [LATENCY-1:0][TAG_W-1:0]       tag_q, tag_d;
  logic [LATENCY-1:0][DATA_TYPE-1:0]   sum_q, sum_d;
  logic [LATENCY-1:0]                  load;
  logic                                ld_chain;

  assign elig = lhs_valid & rhs_valid;

  // Round-robin: scan from last_grant+1, wrapping, first eligible wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = TAG_W'((int'(last_grant_q) + off) % NUM_REQ);
      if (!grant_any && elig[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // A stage may load when empty or when its successor loads; the last stage
  // frees up only when its owner accepts the result. Walked tail-to-head with a
  // scalar so each bit is a plain chain.
  always_comb begin
    load     = '0;
    ld_chain = !valid_q[LATENCY-1] || result_ready[tag_q[LATENCY-1]];
    load[LATENCY-1] = ld_chain;
    for (int k = LATENCY - 2; k >= 0; k--) begin
      ld_chain = !valid_q[k] || ld_chain;
      load[k]  = ld_chain;
    end
  end

  assign accept    = grant_any && load[0] && !rst;
  assign lhs_ready = accept ? grant : '0;
  assign rhs_ready = accept ? grant : '0;

  // Carry out of the top bit is intentionally dropped.
  assign op_sum = lhs[grant_idx*DATA_TYPE +: DATA_TYPE] + rhs[grant_idx*DATA_TYPE +: DATA_TYPE];

  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    sum_d        = sum_q;
    last_grant_d = last_grant_q;
    if (load[0]) begin
      valid_d[0] = accept;
      tag_d[0]   = grant_idx;
      sum_d[0]   = op_sum;
    end
    for (int k = 1; k < LATENCY; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        tag_d[k]   = tag_q[k-1];
        sum_d[k]   = sum_q[k-1];
      end
    end
    if (accept) last_grant_d = grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      tag_q        <= '0;
      sum_q        <= '0;
      last_grant_q <= TAG_W'(NUM_REQ - 1);
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      sum_q        <= sum_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    result_valid = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      result_valid[j] = valid_q[LATENCY-1] && (tag_q[LATENCY-1] == TAG_W'(j));
    end
  end

  assign result = {NUM_REQ{sum_q[LATENCY-1]}};

`ifdef ADDI_SHARED_ARBITER_CONFLICT_COUNT_EN
  logic [31:0] conflict_count_q, conflict_count_d;

  always_comb begin
    conflict_count_d = conflict_count_q;
    if (($countones(elig) >= 2) && (conflict_count_q != 32'hFFFF_FFFF))
      conflict_count_d = conflict_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_count_q <= '0;
    else     conflict_count_q <= conflict_count_d;
  end

  assign conflict_count = conflict_count_q;
`endif

endmodule

// File: tb/tb_addi_shared_arbiter.sv
module tb_addi_shared_arbiter;

  logic        clk;
  logic        rst;

  // Instance 1: LATENCY=1
  logic [63:0] lhs1, rhs1, res1;
  logic [1:0]  l_v1, r_v1, l_r1, r_r1, res_v1, res_r1;
  // Instance 2: LATENCY=2
  logic [63:0] lhs2, rhs2, res2;
  logic [1:0]  l_v2, r_v2, l_r2, r_r2, res_v2, res_r2;

  logic [31:0] exp1 [2];
  logic [31:0] exp2 [2];
  logic [32:0] q1 [$];
  logic [32:0] q2 [$];

  int checks = 0;
  int errors = 0;

`ifdef ADDI_SHARED_ARBITER_CONFLICT_COUNT_EN
  logic [31:0] cc1, cc2;
`endif

  addi_shared_arbiter #(.DATA_TYPE(32), .NUM_REQ(2), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .lhs(lhs1), .lhs_valid(l_v1), .rhs(rhs1), .rhs_valid(r_v1),
    .lhs_ready(l_r1), .rhs_ready(r_r1),
    .result(res1), .result_valid(res_v1), .result_ready(res_r1)
`ifdef ADDI_SHARED_ARBITER_CONFLICT_COUNT_EN
    , .conflict_count(cc1)
`endif
  );

  addi_shared_arbiter #(.DATA_TYPE(32), .NUM_REQ(2), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .lhs(lhs2), .lhs_valid(l_v2), .rhs(rhs2), .rhs_valid(r_v2),
    .lhs_ready(l_r2), .rhs_ready(r_r2),
    .result(res2), .result_valid(res_v2), .result_ready(res_r2)
`ifdef ADDI_SHARED_ARBITER_CONFLICT_COUNT_EN
    , .conflict_count(cc2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    lhs1[i*32 +: 32] = a;
    rhs1[i*32 +: 32] = b;
    exp1[i] = e;
  endtask

  task automatic set2(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    lhs2[i*32 +: 32] = a;
    rhs2[i*32 +: 32] = b;
    exp2[i] = e;
  endtask

  // Scoreboard: accepted operand transfers push their hand-computed sum;
  // every result handshake pops and compares tag and sum.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      q1.delete();
      q2.delete();
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (res_v1[j] && res_r1[j]) begin
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL l1_unexpected actual=tag%0d/%0h required=none", j, res1[j*32 +: 32]);
          end else begin
            e = q1.pop_front();
            chk("l1_tag", 64'(j), 64'(e[32]));
            chk("l1_sum", 64'(res1[j*32 +: 32]), 64'(e[31:0]));
          end
        end
        if (res_v2[j] && res_r2[j]) begin
          if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL l2_unexpected actual=tag%0d/%0h required=none", j, res2[j*32 +: 32]);
          end else begin
            e = q2.pop_front();
            chk("l2_tag", 64'(j), 64'(e[32]));
            chk("l2_sum", 64'(res2[j*32 +: 32]), 64'(e[31:0]));
          end
        end
      end
      for (int j = 0; j < 2; j++) begin
        if (l_v1[j] && r_v1[j] && l_r1[j]) q1.push_back({1'(j), exp1[j]});
        if (l_v2[j] && r_v2[j] && l_r2[j]) q2.push_back({1'(j), exp2[j]});
      end
    end
  end

  initial begin
    rst = 1'b1;
    lhs1 = '0; rhs1 = '0; lhs2 = '0; rhs2 = '0;
    l_v1 = 2'b01; r_v1 = 2'b01; l_v2 = 2'b00; r_v2 = 2'b00;
    res_r1 = 2'b11; res_r2 = 2'b11;
    exp1[0] = '0; exp1[1] = '0; exp2[0] = '0; exp2[1] = '0;

    // Reset: eligible requester must still see ready=0 while rst is high
    step; step;
    @(negedge clk);
    chk("rst_lready", 64'(l_r1), 64'(2'b00));
    chk("rst_rready", 64'(r_r1), 64'(2'b00));
    step;
    rst = 1'b0; l_v1 = 2'b00; r_v1 = 2'b00;
    @(negedge clk);
    chk("post_rst_rv1", 64'(res_v1), 64'(2'b00));
    chk("post_rst_rv2", 64'(res_v2), 64'(2'b00));

    // Single op, latency 1
    step;
    set1(0, 32'd5, 32'd7, 32'd12); l_v1 = 2'b01; r_v1 = 2'b01;
    @(negedge clk);
    chk("single_lready", 64'(l_r1), 64'(2'b01));
    chk("single_rready", 64'(r_r1), 64'(2'b01));
    step;
    l_v1 = 2'b00; r_v1 = 2'b00;
    @(negedge clk);
    chk("single_rvalid", 64'(res_v1), 64'(2'b01));
    chk("single_sum", 64'(res1[31:0]), 64'd12);
    step;
    @(negedge clk);
    chk("single_drain", 64'(res_v1), 64'(2'b00));

    // Round-robin: last grant was req0, so req1 goes first
    step;
    set1(0, 32'd1, 32'd1, 32'd2); set1(1, 32'd10, 32'd10, 32'd20);
    l_v1 = 2'b11; r_v1 = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_grant", 64'(l_r1), (k % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
      if (k > 0) chk("rr_rvalid", 64'(res_v1), (k % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
      step;
    end
    l_v1 = 2'b00; r_v1 = 2'b00;
    step; step;

    // Wrap-around
    set1(0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    l_v1 = 2'b01; r_v1 = 2'b01;
    @(negedge clk);
    chk("wrap_ready", 64'(l_r1), 64'(2'b01));
    step;
    l_v1 = 2'b00; r_v1 = 2'b00;
    @(negedge clk);
    chk("wrap_rvalid", 64'(res_v1), 64'(2'b01));
    chk("wrap_sum", 64'(res1[31:0]), 64'h1);
    step;

    // Partial join: lone lhs on req1, lone rhs on req0
    l_v1 = 2'b10; r_v1 = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("partial_lready", 64'(l_r1), 64'(2'b00));
      chk("partial_rready", 64'(r_r1), 64'(2'b00));
      step;
    end
    l_v1 = 2'b00; r_v1 = 2'b00;

    // Back-pressure on latency-2 instance
    res_r2 = 2'b10;
    set2(0, 32'd1, 32'd2, 32'd3); l_v2 = 2'b01; r_v2 = 2'b01;
    @(negedge clk);
    chk("bp_acc0", 64'(l_r2), 64'(2'b01));
    step;
    set2(0, 32'd3, 32'd4, 32'd7);
    @(negedge clk);
    chk("bp_acc1", 64'(l_r2), 64'(2'b01));
    step;
    set2(0, 32'd5, 32'd6, 32'd11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall_ready", 64'(l_r2), 64'(2'b00));
      chk("bp_hold_valid", 64'(res_v2), 64'(2'b01));
      chk("bp_hold_sum", 64'(res2[31:0]), 64'd3);
      step;
    end
    res_r2 = 2'b11;
    @(negedge clk);
    chk("bp_release_ready", 64'(l_r2), 64'(2'b01));
    step;
    l_v2 = 2'b00; r_v2 = 2'b00;
    repeat (4) step;
    @(negedge clk);
    chk("bp_drained", 64'(q2.size()), 64'd0);

    // Reset with two ops in flight; req1 would be next without the reset
    step;
    res_r2 = 2'b00;
    set2(0, 32'd4, 32'd4, 32'd8); set2(1, 32'd9, 32'd9, 32'd18);
    l_v2 = 2'b11; r_v2 = 2'b11;
    step; step;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 64'(l_r2), 64'(2'b00));
    step;
    rst = 1'b0; l_v2 = 2'b00; r_v2 = 2'b00; res_r2 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_flush", 64'(res_v2), 64'(2'b00));
      step;
    end
    l_v2 = 2'b11; r_v2 = 2'b11;
    @(negedge clk);
    chk("rst_req0_first", 64'(l_r2), 64'(2'b01));
    step;
    l_v2 = 2'b00; r_v2 = 2'b00;
    repeat (4) step;

`ifdef ADDI_SHARED_ARBITER_CONFLICT_COUNT_EN
    rst = 1'b1;
    step;
    rst = 1'b0;
    @(negedge clk);
    chk("cc_reset", 64'(cc1), 64'd0);
    step;
    set1(0, 32'd1, 32'd1, 32'd2); set1(1, 32'd10, 32'd10, 32'd20);
    l_v1 = 2'b11; r_v1 = 2'b11;
    repeat (4) step;
    l_v1 = 2'b01; r_v1 = 2'b01;
    repeat (2) step;
    l_v1 = 2'b00; r_v1 = 2'b00;
    @(negedge clk);
    chk("cc_count", 64'(cc1), 64'd4);
    repeat (4) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    @(negedge clk);
    chk("cc_cleared", 64'(cc1), 64'd0);
    step;
`endif

    @(negedge clk);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    chk("q2_empty", 64'(q2.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
